// File: rtl/mem_host.sv
// Command host for a 4x1 bit-serial memory: bit-serial write, read,
// and optional write read-back verify, with valid/ready on both sides.
module mem_host #(
  parameter int VERIFY = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic       CMD_WR,
  input  logic [3:0] CMD_DATA,
  output logic       RSP_VALID,
  input  logic       RSP_READY,
  output logic [3:0] RSP_DATA,
  output logic       RSP_ERR,
  output logic [1:0] ADDR,
  output logic       IN,
  output logic       RW,
  input  logic       OUT
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DRAIN,
    RESP
  } state_t;

  localparam bit Vfy = (VERIFY != 0);

  state_t     state;
  state_t     state_n;
  logic [1:0] idx;
  logic [1:0] idx_n;
  logic       wr;
  logic [3:0] wdata;
  logic [3:0] rd_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      idx     <= 2'd0;
      wr      <= 1'b0;
      wdata   <= 4'd0;
      rd_data <= 4'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (state == IDLE && CMD_VALID) begin
        wr    <= CMD_WR;
        wdata <= CMD_DATA;
      end
      // OUT lags ADDR by one cycle, so each READ cycle captures the previous bit
      if (state == READ && idx != 2'd0)
        rd_data[idx - 2'd1] <= OUT;
      if (state == DRAIN)
        rd_data[3] <= OUT;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    CMD_READY = 1'b0;
    RSP_VALID = 1'b0;
    ADDR      = 2'd0;
    RW        = 1'b0;
    IN        = 1'b0;
    unique case (state)
      IDLE: begin
        CMD_READY = 1'b1;
        if (CMD_VALID) begin
          idx_n   = 2'd0;
          state_n = CMD_WR ? WRITE : READ;
        end
      end
      WRITE: begin
        ADDR  = idx;
        RW    = 1'b1;
        IN    = wdata[idx];
        idx_n = idx + 2'd1;
        if (idx == 2'd3)
          state_n = Vfy ? READ : RESP;
      end
      READ: begin
        ADDR  = idx;
        idx_n = idx + 2'd1;
        if (idx == 2'd3)
          state_n = DRAIN;
      end
      DRAIN: state_n = RESP;
      RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign RSP_DATA = (wr && !Vfy) ? wdata : rd_data;
  assign RSP_ERR  = wr && Vfy && (rd_data != wdata);

endmodule

// File: tb/tb_mem_host.sv
// Bench for mem_host: instance 0 with VERIFY=0, instance 1 with VERIFY=1,
// each attached to its own registered 4x1 memory model.
module tb_mem_host;

  typedef struct {
    int         d;
    logic [3:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       cmd_valid [2];
  logic       cmd_ready [2];
  logic       cmd_wr    [2];
  logic [3:0] cmd_data  [2];
  logic       rsp_valid [2];
  logic       rsp_ready [2];
  logic [3:0] rsp_data  [2];
  logic       rsp_err   [2];
  logic [1:0] addr      [2];
  logic       din       [2];
  logic       rw        [2];
  logic       mout      [2];
  logic [3:0] mem       [2];
  logic       stuck     [2];

  int   cyc;
  int   checks;
  int   failures;
  bit   seen;
  exp_t q[$];

  mem_host #(.VERIFY(0)) u0 (
    .CLK(clk), .RST(rst),
    .CMD_VALID(cmd_valid[0]), .CMD_READY(cmd_ready[0]),
    .CMD_WR(cmd_wr[0]), .CMD_DATA(cmd_data[0]),
    .RSP_VALID(rsp_valid[0]), .RSP_READY(rsp_ready[0]),
    .RSP_DATA(rsp_data[0]), .RSP_ERR(rsp_err[0]),
    .ADDR(addr[0]), .IN(din[0]), .RW(rw[0]), .OUT(mout[0])
  );

  mem_host #(.VERIFY(1)) u1 (
    .CLK(clk), .RST(rst),
    .CMD_VALID(cmd_valid[1]), .CMD_READY(cmd_ready[1]),
    .CMD_WR(cmd_wr[1]), .CMD_DATA(cmd_data[1]),
    .RSP_VALID(rsp_valid[1]), .RSP_READY(rsp_ready[1]),
    .RSP_DATA(rsp_data[1]), .RSP_ERR(rsp_err[1]),
    .ADDR(addr[1]), .IN(din[1]), .RW(rw[1]), .OUT(mout[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rw[d])
        mem[d][addr[d]] <= din[d];
      else
        mout[d] <= (stuck[d] && addr[d] == 2'd2) ? 1'b0 : mem[d][addr[d]];
    end
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        if (rsp_valid[d]) begin
          if (q.size() == 0) begin
            check("unexpected_rsp", 32'(d), 32'hffff);
          end else begin
            if (!seen) begin
              check("rsp_latency", cyc, q[0].cyc);
              seen = 1'b1;
            end
            check("rsp_dut", d, q[0].d);
            check("rsp_data", rsp_data[d], q[0].data);
            check("rsp_err", rsp_err[d], q[0].err);
            if (rsp_ready[d]) begin
              void'(q.pop_front());
              seen = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int d, logic [3:0] data, logic err, int at);
    exp_t e;
    e.d = d;
    e.data = data;
    e.err = err;
    e.cyc = at;
    q.push_back(e);
  endtask

  task automatic issue(int d, bit wr, logic [3:0] data,
                       logic [3:0] ed, bit ee, int lat, bit exp_rsp);
    int n;
    step();
    cmd_valid[d] = 1'b1;
    cmd_wr[d] = wr;
    cmd_data[d] = data;
    n = 0;
    while (!cmd_ready[d] && n < 50) begin
      step();
      n++;
    end
    if (!cmd_ready[d])
      check("accept_timeout", 0, 1);
    if (exp_rsp)
      push(d, ed, ee, cyc + lat);
    step();
    cmd_valid[d] = 1'b0;
  endtask

  task automatic pins(int d, bit erw, logic [3:0] ein);
    for (int i = 0; i < 4; i++) begin
      check("pin_addr", addr[d], i);
      check("pin_rw", rw[d], erw);
      check("pin_in", din[d], ein[i]);
      step();
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      check("rsp_timeout", q.size(), 0);
      q.delete();
      seen = 1'b0;
    end
  endtask

  initial begin
    int c;
    int n;
    checks = 0;
    failures = 0;
    seen = 1'b0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cmd_valid[d] = 1'b0;
      cmd_wr[d] = 1'b0;
      cmd_data[d] = 4'd0;
      rsp_ready[d] = 1'b1;
      mem[d] = 4'd0;
      mout[d] = 1'b0;
      stuck[d] = 1'b0;
    end
    step();
    step();
    rst = 1'b0;

    for (int d = 0; d < 2; d++) begin
      check("rst_cmd_ready", cmd_ready[d], 1);
      check("rst_rsp_valid", rsp_valid[d], 0);
      check("rst_rsp_data", rsp_data[d], 0);
      check("rst_rsp_err", rsp_err[d], 0);
      check("rst_addr", addr[d], 0);
      check("rst_rw", rw[d], 0);
      check("rst_in", din[d], 0);
    end

    issue(0, 1'b1, 4'b1011, 4'b1011, 1'b0, 5, 1'b1);
    pins(0, 1'b1, 4'b1011);
    wait_done();
    issue(0, 1'b0, 4'b0000, 4'b1011, 1'b0, 6, 1'b1);
    pins(0, 1'b0, 4'b0000);
    wait_done();
    issue(0, 1'b1, 4'b0100, 4'b0100, 1'b0, 5, 1'b1);
    wait_done();
    issue(0, 1'b0, 4'b1111, 4'b0100, 1'b0, 6, 1'b1);
    wait_done();
    issue(0, 1'b1, 4'b1011, 4'b1011, 1'b0, 5, 1'b1);
    wait_done();

    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 4'b0000, 4'b1011, 1'b0, 6, 1'b1);
    n = 0;
    while (!rsp_valid[0] && n < 20) begin
      step();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_cmd_ready", cmd_ready[0], 0);
      check("bp_rsp_valid", rsp_valid[0], 1);
      cmd_valid[0] = i[0];
      cmd_wr[0] = 1'b1;
      step();
    end
    cmd_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    step();
    check("bp_idle_ready", cmd_ready[0], 1);
    check("bp_idle_valid", rsp_valid[0], 0);
    wait_done();

    issue(0, 1'b1, 4'b1011, 4'b0000, 1'b0, 0, 1'b0);
    step();
    step();
    check("abort_addr", addr[0], 2);
    check("abort_rw_pre", rw[0], 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_rw", rw[0], 0);
    check("abort_cmd_ready", cmd_ready[0], 1);
    check("abort_rsp_valid", rsp_valid[0], 0);
    issue(0, 1'b0, 4'b0000, 4'b1011, 1'b0, 6, 1'b1);
    wait_done();

    step();
    cmd_valid[0] = 1'b1;
    cmd_wr[0] = 1'b0;
    check("b2b_ready", cmd_ready[0], 1);
    c = cyc;
    push(0, 4'b1011, 1'b0, c + 6);
    push(0, 4'b1011, 1'b0, c + 13);
    n = 0;
    while (cyc < c + 8 && n < 20) begin
      step();
      n++;
    end
    cmd_valid[0] = 1'b0;
    wait_done();

    issue(1, 1'b1, 4'b0110, 4'b0110, 1'b0, 10, 1'b1);
    wait_done();
    issue(1, 1'b0, 4'b0000, 4'b0110, 1'b0, 6, 1'b1);
    wait_done();
    stuck[1] = 1'b1;
    issue(1, 1'b1, 4'b0110, 4'b0010, 1'b1, 10, 1'b1);
    wait_done();
    issue(1, 1'b0, 4'b0000, 4'b0010, 1'b0, 6, 1'b1);
    wait_done();

    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_host.md
MEM_HOST -- requirements
Module: mem_host

Interface
REQ-001 Parameter: VERIFY, default 1, meaning 1 = every write is followed by an automatic read-back and compare, 0 = write only.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 CMD_VALID  input  1  command request.
REQ-005 CMD_READY  output  1  host can accept a command.
REQ-006 CMD_WR  input  1  1 = write command, 0 = read command.
REQ-007 CMD_DATA  input  4  word to write; ignored for reads.
REQ-008 RSP_VALID  output  1  response available.
REQ-009 RSP_READY  input  1  consumer accepts response.
REQ-010 RSP_DATA  output  4  word read back, or written word when no read-back occurs.
REQ-011 RSP_ERR  output  1  read-back mismatch flag.
REQ-012 ADDR  output  2  bit address to the 4x1 bit-serial memory.
REQ-013 IN  output  1  write bit to memory.
REQ-014 RW  output  1  1 = memory write, 0 = memory read.
REQ-015 OUT  input  1  memory read bit; registered by the memory, valid one cycle after ADDR is presented with RW=0.

Function
REQ-016 States SHALL be IDLE, WRITE, READ, DRAIN, RESP, with a 2-bit bit index IDX.
REQ-017 CMD_READY SHALL be 1 only in IDLE; a command is accepted on the edge with CMD_VALID=1 and CMD_READY=1; CMD_WR and CMD_DATA are latched on that edge.
REQ-018 On acceptance: write -> WRITE with IDX=0; read -> READ with IDX=0.
REQ-019 In WRITE, outputs SHALL be ADDR=IDX, RW=1, IN=latched_data[IDX]; IDX increments each cycle; after IDX=3: go to READ (IDX=0) if VERIFY=1, otherwise to RESP.
REQ-020 In READ, outputs SHALL be ADDR=IDX, RW=0, IN=0; IDX increments each cycle; after IDX=3 go to DRAIN.
REQ-021 Capture: in READ with IDX=k>0, OUT SHALL be stored to rd_data[k-1]; in DRAIN, OUT SHALL be stored to rd_data[3]; DRAIN lasts exactly one cycle, then RESP.
REQ-022 In IDLE, DRAIN and RESP, outputs SHALL be ADDR=0, RW=0, IN=0.
REQ-023 In RESP, RSP_VALID=1 and RSP_DATA/RSP_ERR SHALL be held stable until the edge with RSP_READY=1; then go to IDLE.
REQ-024 RSP_DATA: read or verified write -> rd_data; write with VERIFY=0 -> latched write data.
REQ-025 RSP_ERR = 1 only for a verified write whose rd_data differs from the latched write data; 0 for reads and unverified writes.
REQ-026 Latency from acceptance edge T0 to first RSP_VALID cycle: read = T6; write with VERIFY=0 = T5; write with VERIFY=1 = T10.
REQ-027 RSP_READY held high in advance SHALL complete the response in its first RSP_VALID cycle; CMD_READY SHALL rise the following cycle (no same-cycle command and response overlap).
REQ-028 CMD_VALID outside IDLE SHALL be ignored; RSP_READY outside RESP SHALL be ignored.

Reset
REQ-029 RST=1 on an edge SHALL force IDLE, IDX=0, latched data=0, rd_data=0, RSP_VALID=0, RSP_ERR=0, RSP_DATA=0, CMD_READY=1 after the edge, ADDR=0, RW=0, IN=0, overriding any other event on that edge.
REQ-030 Reset mid-operation SHALL abort the command with no response; memory contents partially written are not defined by this block.

Verification
REQ-031 VERIFY=0: write 4'b1011 -> RW=1 for 4 cycles, ADDR 0,1,2,3 with IN 1,1,0,1; RSP_VALID at T5, RSP_DATA=4'b1011, RSP_ERR=0.
REQ-032 After REQ-031, read -> RW=0, ADDR 0..3 on T1..T4; RSP_VALID at T6 with RSP_DATA=4'b1011.
REQ-033 VERIFY=1 with the memory model: write 4'b0110 -> RSP_VALID at T10, RSP_DATA=4'b0110, RSP_ERR=0; with the memory bit 2 forced to 0 -> RSP_DATA=4'b0010, RSP_ERR=1.
REQ-034 Backpressure: RSP_READY=0 for 5 cycles in RESP -> RSP_VALID/RSP_DATA stable, CMD_READY=0, CMD_VALID pulses ignored; RSP_READY=1 -> IDLE next cycle.
REQ-035 RST=1 during WRITE IDX=2 -> next cycle IDLE, RW=0, CMD_READY=1, no RSP_VALID; a new read afterwards completes normally.
REQ-036 Back-to-back: CMD_VALID held high with two reads -> second accepted on the cycle after the first response handshake, second RSP_VALID six cycles later.
